// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;
  localparam int WDOG_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog down-counter: clear loads LOAD, enable decrements, tc flags the LOAD-th enabled cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = WDOG_W,
  parameter int LOAD  = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= WIDTH'(LOAD);
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // A count of one means this is the last permitted cycle of waiting.
  assign tc = (count == WIDTH'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving an icache (m0) and a dcache (m1) access to one line-wide memory port.
//
// state | meaning
// IDLE  | waiting for a request; grants and launches the memory access
// BUSY  | memory access outstanding; watchdog running
// DONE  | ack pulse to the granted port; memory enable low
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   any_req;
  logic   pick;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_tc;

  // On a tie the port that was not served last wins; a lone requester always wins.
  always_comb begin
    any_req = m0_req_i | m1_req_i;
    pick    = 1'b0;
    if (m0_req_i && m1_req_i) begin
      pick = ~last_grant;
    end else begin
      pick = m1_req_i;
    end
  end

  assign wd_clear  = (state == IDLE) && any_req;
  assign wd_enable = (state == BUSY);

  mem_arb_timer #(
    .WIDTH (WDOG_W),
    .LOAD  (TIMEOUT)
  ) u_timer (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (wd_clear),
    .enable (wd_enable),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      rdata_o      <= '0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
          if (any_req) begin
            grant        <= pick;
            last_grant   <= pick;
            mem_enable_o <= 1'b1;
            mem_write_o  <= pick ? m1_write_i : m0_write_i;
            mem_addr_o   <= pick ? m1_addr_i  : m0_addr_i;
            mem_data_o   <= pick ? m1_data_i  : m0_data_i;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // A completion arriving on the timeout cycle is still a normal completion.
          if (mem_ack_i) begin
            if (!mem_write_o) begin
              rdata_o <= mem_data_i;
            end
            mem_enable_o <= 1'b0;
            m0_ack_o     <= ~grant;
            m1_ack_o     <= grant;
            state        <= DONE;
          end else if (wd_tc) begin
            mem_enable_o <= 1'b0;
            err_o        <= 1'b1;
            m0_ack_o     <= ~grant;
            m1_ack_o     <= grant;
            state        <= DONE;
          end
        end
        DONE: begin
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: planned transactions feed a memory responder and an ack monitor.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 4;

  logic          clk;
  logic          rst_i;
  logic          m0_req_i, m0_write_i, m0_ack_o;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i;
  logic          m1_req_i, m1_write_i, m1_ack_o;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;
  logic          mem_ack_i;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .m0_req_i     (m0_req_i),
    .m0_write_i   (m0_write_i),
    .m0_addr_i    (m0_addr_i),
    .m0_data_i    (m0_data_i),
    .m0_ack_o     (m0_ack_o),
    .m1_req_i     (m1_req_i),
    .m1_write_i   (m1_write_i),
    .m1_addr_i    (m1_addr_i),
    .m1_data_i    (m1_data_i),
    .m1_ack_o     (m1_ack_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            dly;
    logic [DW-1:0] rd;
  } mem_t;

  typedef struct {
    bit            prt;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  op_t  op0_q[$];
  op_t  op1_q[$];
  int   dly_q[$];
  mem_t mem_q[$];
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  bit            m_last;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  bit            use_force;
  logic [DW-1:0] force_rd;
  bit            resp_en;
  int            exp_ack_cyc;
  int            last_fall;
  bit            have_fall;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.wr   = 1'($urandom_range(0, 1));
    o.addr = $urandom;
    o.data = rand_line();
    return o;
  endfunction

  task automatic model_reset();
    m_last    = 1'b1;
    m_rdata   = '0;
    m_err     = 1'b0;
    have_fall = 1'b0;
    exp_q.delete();
    mem_q.delete();
  endtask

  // Reference model: serve both ports alternately while both have work, then drain the other.
  task automatic plan_burst();
    int   i0, i1;
    bit   p;
    op_t  o;
    mem_t m;
    exp_t e;
    i0 = 0;
    i1 = 0;
    while (i0 < op0_q.size() || i1 < op1_q.size()) begin
      if (i0 < op0_q.size() && i1 < op1_q.size()) p = ~m_last;
      else p = (i1 < op1_q.size());
      m_last = p;
      if (p) begin o = op1_q[i1]; i1++; end
      else begin o = op0_q[i0]; i0++; end
      m.wr   = o.wr;
      m.addr = o.addr;
      m.data = o.data;
      m.dly  = (dly_q.size() > 0) ? dly_q.pop_front() : $urandom_range(1, TO + 2);
      m.rd   = use_force ? force_rd : rand_line();
      mem_q.push_back(m);
      if (m.dly > TO) m_err = 1'b1;
      else if (!o.wr) m_rdata = m.rd;
      e.prt   = p;
      e.rdata = m_rdata;
      e.err   = m_err;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_port(input bit p, input int n);
    op_t o;
    bit  seen;
    for (int k = 0; k < n; k++) begin
      o = p ? op1_q[k] : op0_q[k];
      @(negedge clk);
      if (p) begin
        m1_req_i = 1'b1; m1_write_i = o.wr; m1_addr_i = o.addr; m1_data_i = o.data;
      end else begin
        m0_req_i = 1'b1; m0_write_i = o.wr; m0_addr_i = o.addr; m0_data_i = o.data;
      end
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
        @(negedge clk);
        seen = p ? m1_ack_o : m0_ack_o;
      end
      if (p) m1_req_i = 1'b0;
      else m0_req_i = 1'b0;
      if (!seen) begin
        n_chk++;
        n_fail++;
        $display("FAIL ack_wait_port%0d: no ack within 100 cycles, required an ack", p);
        return;
      end
    end
  endtask

  task automatic run_burst();
    int n0, n1;
    n0 = op0_q.size();
    n1 = op1_q.size();
    have_fall = 1'b0;
    plan_burst();
    fork
      drive_port(1'b0, n0);
      drive_port(1'b1, n1);
    join
    @(negedge clk);
    check("burst_exp_drained", 256'(exp_q.size()), 256'd0);
    check("burst_mem_drained", 256'(mem_q.size()), 256'd0);
    op0_q.delete();
    op1_q.delete();
    dly_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_enable"}, mem_enable_o, 0);
    check({tag, "_mem_write"}, mem_write_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_data"}, mem_data_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_m0_ack"}, m0_ack_o, 0);
    check({tag, "_m1_ack"}, m1_ack_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    check_outputs_zero("reset");
  endtask

  // Memory responder: acks in BUSY cycle dly (N = dly-1), stays silent when dly exceeds the watchdog.
  initial begin
    mem_t cur;
    int   cnt, lim;
    bit   busy;
    busy = 1'b0;
    cnt = 0;
    lim = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_ack_i  = 1'b0;
        mem_data_i = rand_line();
        if (!busy && mem_enable_o) begin
          if (mem_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL mem_unexpected: mem_enable_o=1 with nothing planned, required 0");
          end else begin
            cur = mem_q.pop_front();
            busy = 1'b1;
            cnt = 0;
            lim = (cur.dly < TO) ? cur.dly : TO;
            exp_ack_cyc = cyc + lim;
            check("mem_write", mem_write_o, cur.wr);
            check("mem_addr", mem_addr_o, cur.addr);
            check("mem_data", mem_data_o, cur.data);
            if (have_fall)
              check("enable_gap_1_to_2", ((cyc - last_fall) >= 1) && ((cyc - last_fall) <= 2), 1);
          end
        end
        if (busy) begin
          cnt++;
          if (cnt <= lim) begin
            check("mem_enable_held", mem_enable_o, 1);
            check("mem_addr_held", mem_addr_o, cur.addr);
            if (cnt == cur.dly) begin
              mem_ack_i  = 1'b1;
              mem_data_i = cur.rd;
            end
          end else begin
            check("mem_enable_drop", mem_enable_o, 0);
            last_fall = cyc;
            have_fall = 1'b1;
            busy = 1'b0;
          end
        end
      end
    end
  end

  // Ack monitor: every ack pulse pops one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) begin
        check("ack_not_both", m0_ack_o && m1_ack_o, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ack_unexpected: m0_ack_o=%0d m1_ack_o=%0d, required 0", m0_ack_o, m1_ack_o);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", m1_ack_o, e.prt);
          check("ack_rdata", rdata_o, e.rdata);
          check("ack_err", err_o, e.err);
          check("ack_cycle", 256'(cyc), 256'(exp_ack_cyc));
        end
      end
    end
  end

  initial begin
    op_t o;
    m0_req_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
    m1_req_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
    rst_i = 1'b1;
    resp_en = 1'b1;
    use_force = 1'b0;
    force_rd = '0;
    exp_ack_cyc = 0;
    last_fall = 0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    check_outputs_zero("por");

    // m1 read of 0x40, memory acks 3 cycles after enable (coincides with the watchdog limit)
    o.wr = 1'b0; o.addr = 32'h40; o.data = '0;
    op1_q.push_back(o);
    dly_q.push_back(4);
    use_force = 1'b1;
    force_rd = {32{8'hA5}};
    run_burst();
    use_force = 1'b0;
    check("req037_rdata_held", rdata_o, {32{8'hA5}});
    check("req037_no_err", err_o, 0);

    // simultaneous first requests after reset: m0 then m1
    do_reset();
    op0_q.push_back(rand_op());
    op1_q.push_back(rand_op());
    run_burst();

    // both ports re-requesting: 0,1,0,1,0,1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      op0_q.push_back(rand_op());
      op1_q.push_back(rand_op());
    end
    for (int i = 0; i < 6; i++) dly_q.push_back($urandom_range(1, 3));
    run_burst();

    // read to load rdata, then an unanswered write that must time out
    do_reset();
    o.wr = 1'b0; o.addr = 32'h10; o.data = '0;
    op0_q.push_back(o);
    dly_q.push_back(2);
    run_burst();
    o.wr = 1'b1; o.addr = 32'h80; o.data = 256'h1234;
    op0_q.push_back(o);
    dly_q.push_back(20);
    run_burst();
    repeat (3) @(negedge clk);
    check("err_sticky", err_o, 1);

    // randomized bursts, occasionally reset in between
    for (int b = 0; b < 14; b++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int i = $urandom_range(0, 3); i > 0; i--) op0_q.push_back(rand_op());
      for (int i = $urandom_range(0, 3); i > 0; i--) op1_q.push_back(rand_op());
      run_burst();
    end

    // reset in BUSY, then a stray memory ack
    do_reset();
    resp_en = 1'b0;
    @(negedge clk);
    m0_req_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h200;
    for (int i = 0; i < 20 && !mem_enable_o; i++) @(negedge clk);
    check("rst_busy_enable", mem_enable_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    m0_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_data_i = rand_line();
    @(negedge clk);
    mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("stray_ack");
    model_reset();
    resp_en = 1'b1;
    op0_q.push_back(rand_op());
    op1_q.push_back(rand_op());
    run_burst();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

endmodule
